// File: rtl/phase_a_io_pkg.sv
// phase_a_io_pkg: shared constants and the FSM state type for the phase_a
// operand loader / result unloader.
//   W            stream word width
//   NA/NMN/NMP   word counts for m and a, m_n, m_prime
//   CNT_W        width of the per-field word counter
package phase_a_io_pkg;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  localparam int SIZE        = 3072;
  localparam int RADIX       = 108;
  localparam int W           = 64;
  localparam int TIMEOUT_DEF = 32;

  localparam int NA    = SIZE / W;                 // 48
  localparam int NMN   = ceil_div(SIZE + 2, W);    // 49
  localparam int NMP   = ceil_div(RADIX + 2, W);   // 2
  localparam int CNT_W = $clog2(NMN);

  typedef enum logic [2:0] {
    IDLE, LD_M, LD_MN, LD_MP, LD_A, RUN, DRAIN
  } state_t;

endpackage

// File: rtl/word_unpack.sv
// word_unpack: assembles a wide register from W-bit words written by index.
//   clk, rst_n  clock, synchronous active-low reset (clears the register)
//   we, idx     write strobe and word index (word 0 = least significant)
//   data        incoming word; bits past WIDTH in the top word are dropped
//   q           assembled register
module word_unpack
  import phase_a_io_pkg::*;
#(
  parameter int WIDTH  = SIZE,
  parameter int NWORDS = NA,
  parameter int WORD_W = W,
  parameter int IDX_W  = CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] data,
  output logic [WIDTH-1:0]  q
);

  for (genvar g = 0; g < NWORDS; g++) begin : g_word
    localparam int LO = g * WORD_W;
    // The top word may be only partially used by the field.
    localparam int WB = (WIDTH - LO < WORD_W) ? (WIDTH - LO) : WORD_W;

    logic [WB-1:0] r;

    always_ff @(posedge clk) begin
      if (!rst_n)                            r <= '0;
      else if (we && idx == IDX_W'(g))       r <= data[WB-1:0];
    end

    assign q[LO +: WB] = r;
  end

endmodule

// File: rtl/phase_a_io_ctrl.sv
// phase_a_io_ctrl: loads key (m, m_n, m_prime) and operand a from a word
// stream, launches phase_a, captures new_a on en_out and streams it back.
//   s_valid/s_ready/s_data/reuse_key  input word stream (LSW first per field)
//   m_valid/m_ready/m_data/m_last     result word stream (LSW first)
//   pa_*                              phase_a operand, control and result
//   busy                              any state other than IDLE
//   err                               sticky: missing key or phase_a timeout
module phase_a_io_ctrl
  import phase_a_io_pkg::*;
#(
  parameter int Size    = SIZE,
  parameter int radix   = RADIX,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [W-1:0]       s_data,
  input  logic               reuse_key,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [W-1:0]       m_data,
  output logic               m_last,
  output logic [Size-1:0]    pa_a,
  output logic [Size-1:0]    pa_m,
  output logic [Size+1:0]    pa_m_n,
  output logic [radix+1:0]   pa_m_prime,
  output logic               pa_en,
  input  logic [Size-1:0]    pa_new_a,
  input  logic               pa_en_out,
  output logic               busy,
  output logic               err
);

  localparam int NWA  = Size / W;
  localparam int NWMN = ceil_div(Size + 2, W);
  localparam int NWMP = ceil_div(radix + 2, W);
  localparam int CW   = $clog2(NWMN);
  localparam int RW   = $clog2(TIMEOUT + 1);

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          idx;
  logic [RW-1:0]          run_cnt;
  logic                   key_loaded;
  logic [NWA-1:0][W-1:0]  result;

  logic acc, fast_start;
  logic we_m, we_mn, we_mp, we_a;

  assign acc        = s_valid & s_ready;
  // In IDLE: does this first beat belong to a (key already resident)?
  assign fast_start = reuse_key & key_loaded;

  // cnt is 0 in IDLE, so the first beat lands in word 0 of its field.
  assign we_m  = acc & ((state == LD_M) | ((state == IDLE) & ~fast_start));
  assign we_mn = acc & (state == LD_MN);
  assign we_mp = acc & (state == LD_MP);
  assign we_a  = acc & ((state == LD_A) | ((state == IDLE) & fast_start));

  word_unpack #(.WIDTH(Size),      .NWORDS(NWA),  .WORD_W(W), .IDX_W(CW)) u_m
    (.clk(clk), .rst_n(rst_n), .we(we_m),  .idx(cnt), .data(s_data), .q(pa_m));
  word_unpack #(.WIDTH(Size + 2),  .NWORDS(NWMN), .WORD_W(W), .IDX_W(CW)) u_mn
    (.clk(clk), .rst_n(rst_n), .we(we_mn), .idx(cnt), .data(s_data), .q(pa_m_n));
  word_unpack #(.WIDTH(radix + 2), .NWORDS(NWMP), .WORD_W(W), .IDX_W(CW)) u_mp
    (.clk(clk), .rst_n(rst_n), .we(we_mp), .idx(cnt), .data(s_data), .q(pa_m_prime));
  word_unpack #(.WIDTH(Size),      .NWORDS(NWA),  .WORD_W(W), .IDX_W(CW)) u_a
    (.clk(clk), .rst_n(rst_n), .we(we_a),  .idx(cnt), .data(s_data), .q(pa_a));

  // Output side decodes straight from registered state, so it is stable
  // while the consumer stalls.
  assign busy    = (state != IDLE);
  assign m_valid = (state == DRAIN);
  assign m_data  = result[idx];
  assign m_last  = m_valid & (idx == CW'(NWA - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      run_cnt    <= '0;
      key_loaded <= 1'b0;
      result     <= '0;
      s_ready    <= 1'b0;
      pa_en      <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          s_ready <= 1'b1;
          if (acc) begin
            cnt <= CW'(1);
            if (fast_start) begin
              state <= LD_A;
            end else begin
              state <= LD_M;
              // Reuse requested with no resident key: load as a full frame.
              if (reuse_key) err <= 1'b1;
            end
          end
        end
        LD_M: if (acc) begin
          if (cnt == CW'(NWA - 1)) begin cnt <= '0; state <= LD_MN; end
          else cnt <= cnt + CW'(1);
        end
        LD_MN: if (acc) begin
          if (cnt == CW'(NWMN - 1)) begin cnt <= '0; state <= LD_MP; end
          else cnt <= cnt + CW'(1);
        end
        LD_MP: if (acc) begin
          if (cnt == CW'(NWMP - 1)) begin
            cnt        <= '0;
            state      <= LD_A;
            key_loaded <= 1'b1;
          end else cnt <= cnt + CW'(1);
        end
        LD_A: if (acc) begin
          if (cnt == CW'(NWA - 1)) begin
            cnt     <= '0;
            state   <= RUN;
            s_ready <= 1'b0;
            pa_en   <= 1'b1;
            run_cnt <= '0;
          end else cnt <= cnt + CW'(1);
        end
        RUN: begin
          // en_out wins over expiry when both land on the same cycle.
          if (pa_en_out) begin
            result <= pa_new_a;
            pa_en  <= 1'b0;
            idx    <= '0;
            state  <= DRAIN;
          end else if (run_cnt == RW'(TIMEOUT - 1)) begin
            err        <= 1'b1;
            pa_en      <= 1'b0;
            key_loaded <= 1'b0;
            s_ready    <= 1'b1;
            state      <= IDLE;
          end else begin
            run_cnt <= run_cnt + RW'(1);
          end
        end
        DRAIN: if (m_ready) begin
          if (idx == CW'(NWA - 1)) begin
            idx     <= '0;
            s_ready <= 1'b1;
            state   <= IDLE;
          end else idx <= idx + CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_a_io_ctrl.sv
module tb_phase_a_io_ctrl;
  localparam int SZ  = 3072;
  localparam int RX  = 108;
  localparam int WW  = 64;
  localparam int NA  = 48;
  localparam int NMN = 49;
  localparam int NMP = 2;
  localparam int WX  = SZ + 2;

  typedef struct {
    bit          reuse;      // reuse_key presented on the first beat
    int          exp_beats;  // 147 = full frame expected, 48 = a only
    bit          a_rand;
    logic [63:0] a_lo;       // a word 0 when not random (other words 0)
    bit          stub_on;    // stub answers with en_out
    bit          toggle;     // m_ready alternates in DRAIN
    bit          stall;      // insert s_valid bubbles
    bit          res_pat;    // multi-word result pattern
    logic [63:0] res_w0;     // result word 0 when no pattern
    bit          exp_err;
  } vec_t;

  logic              clk = 0, rst_n = 0;
  logic              s_valid = 0, reuse_key = 0, m_ready = 0;
  logic [WW-1:0]     s_data = '0;
  logic              s_ready, m_valid, m_last, pa_en, busy, err;
  logic [WW-1:0]     m_data;
  logic [SZ-1:0]     pa_a, pa_m, pa_new_a;
  logic [SZ+1:0]     pa_m_n;
  logic [RX+1:0]     pa_m_prime;
  logic              pa_en_out = 0;

  logic [SZ-1:0]     stub_val = '0;
  bit                stub_on = 0;
  int                stub_cnt = 0;

  int                n_cmp = 0, n_mis = 0;
  logic [WW-1:0]     sb[$];
  logic [WW-1:0]     beat_q[$];
  logic [SZ-1:0]     exp_m = '0, exp_a = '0;
  logic [SZ+1:0]     exp_mn = '0;
  logic [RX+1:0]     exp_mp = '0;

  phase_a_io_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .reuse_key(reuse_key),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .pa_a(pa_a), .pa_m(pa_m), .pa_m_n(pa_m_n), .pa_m_prime(pa_m_prime),
    .pa_en(pa_en), .pa_new_a(pa_new_a), .pa_en_out(pa_en_out),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // phase_a stand-in: one en_out pulse 20 cycles after the en rise.
  always @(posedge clk) begin
    if (!pa_en) begin
      stub_cnt  <= 0;
      pa_en_out <= 1'b0;
    end else begin
      stub_cnt  <= stub_cnt + 1;
      pa_en_out <= stub_on && (stub_cnt == 19);
    end
  end
  // Garbage outside the pulse so a mistimed capture shows up.
  assign pa_new_a = pa_en_out ? stub_val : ~stub_val;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [WX-1:0] act, input logic [WX-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got[63:0] %h want[63:0] %h", nm, act[63:0], exp[63:0]);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat is taken.
  task automatic send_beat(input logic [WW-1:0] d, input logic rk);
    int t = 0;
    s_valid = 1'b1; s_data = d; reuse_key = rk;
    while (!s_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) chk("s_ready_timeout", 64'(s_ready), 64'(1));
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; stub_on = 0;
    sb.delete();
    exp_m = '0; exp_mn = '0; exp_mp = '0; exp_a = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_frame(input vec_t v);
    logic [WW-1:0]     w;
    logic [NMN*WW-1:0] tmn;
    logic [NMP*WW-1:0] tmp;
    beat_q.delete();
    if (v.exp_beats == 147) begin
      for (int i = 0; i < NA; i++) begin
        w = {$urandom, $urandom}; beat_q.push_back(w); exp_m[i*WW +: WW] = w;
      end
      for (int i = 0; i < NMN; i++) begin
        w = {$urandom, $urandom}; beat_q.push_back(w); tmn[i*WW +: WW] = w;
      end
      for (int i = 0; i < NMP; i++) begin
        w = {$urandom, $urandom}; beat_q.push_back(w); tmp[i*WW +: WW] = w;
      end
      exp_mn = tmn[SZ+1:0];
      exp_mp = tmp[RX+1:0];
    end
    for (int i = 0; i < NA; i++) begin
      w = v.a_rand ? {$urandom, $urandom} : ((i == 0) ? v.a_lo : '0);
      beat_q.push_back(w); exp_a[i*WW +: WW] = w;
    end
    stub_on = v.stub_on;
    if (v.stub_on) begin
      for (int k = 0; k < NA; k++) begin
        w = v.res_pat ? {32'hC0DE0000 + 32'(k), 32'h5A5A0000 + 32'(k)}
                      : ((k == 0) ? v.res_w0 : '0);
        stub_val[k*WW +: WW] = w;
        sb.push_back(w);
      end
    end
    for (int i = 0; i < beat_q.size(); i++) begin
      if (v.stall && (i % 5 == 2)) begin s_valid = 1'b0; @(negedge clk); end
      send_beat(beat_q[i], (i == 0) ? v.reuse : 1'($urandom_range(0, 1)));
      if (v.exp_beats == 147 && i == NA - 1) chk("no_early_launch", 64'(pa_en), 64'(0));
    end
    chk("launch_pa_en", 64'(pa_en), 64'(1));
    chk("launch_s_ready", 64'(s_ready), 64'(0));
    chk("launch_busy", 64'(busy), 64'(1));
    chkw("pa_m", WX'(pa_m), WX'(exp_m));
    chkw("pa_m_n", pa_m_n, exp_mn);
    chkw("pa_m_prime", WX'(pa_m_prime), WX'(exp_mp));
    chkw("pa_a", WX'(pa_a), WX'(exp_a));
  endtask

  task automatic drain(input bit toggle);
    int k = 0, cyc = 0;
    bit hv = 0;
    logic [WW-1:0] held, e;
    while (k < NA && cyc < 400) begin
      m_ready = toggle ? 1'(cyc % 2) : 1'b1;
      if (m_valid) begin
        if (hv) chk("m_data_hold", m_data, held);
        if (m_ready) begin
          if (sb.size() > 0) e = sb.pop_front(); else e = 'x;
          chk("m_data", m_data, e);
          chk("m_last", 64'(m_last), 64'(k == NA - 1));
          k++; hv = 0;
        end else begin
          held = m_data; hv = 1;
        end
      end
      @(negedge clk); cyc++;
    end
    m_ready = 1'b0;
    if (k < NA) chk("drain_timeout", 64'(k), 64'(NA));
  endtask

  task automatic run_vec(input vec_t v);
    int n = 0;
    send_frame(v);
    if (v.stub_on) begin
      drain(v.toggle);
      chk("done_busy", 64'(busy), 64'(0));
      chk("done_m_valid", 64'(m_valid), 64'(0));
      chk("done_s_ready", 64'(s_ready), 64'(1));
      chk("done_pa_en", 64'(pa_en), 64'(0));
      chk("sb_empty", 64'(sb.size()), 64'(0));
    end else begin
      while (busy && n < 100) begin @(negedge clk); n++; end
      chk("timeout_cycles", 64'(n), 64'(32));
      chk("timeout_pa_en", 64'(pa_en), 64'(0));
      chk("timeout_s_ready", 64'(s_ready), 64'(1));
    end
    chk("err", 64'(err), 64'(v.exp_err));
  endtask

  initial begin
    vec_t tbl[4];
    vec_t v;
    tbl[0] = '{reuse:0, exp_beats:147, a_rand:1, a_lo:64'h0, stub_on:1, toggle:0,
               stall:1, res_pat:0, res_w0:64'h1234, exp_err:0};
    tbl[1] = '{reuse:1, exp_beats:48, a_rand:0, a_lo:64'h5, stub_on:1, toggle:0,
               stall:0, res_pat:1, res_w0:64'h0, exp_err:0};
    tbl[2] = '{reuse:0, exp_beats:147, a_rand:1, a_lo:64'h0, stub_on:1, toggle:1,
               stall:0, res_pat:1, res_w0:64'h0, exp_err:0};
    tbl[3] = '{reuse:1, exp_beats:48, a_rand:1, a_lo:64'h0, stub_on:1, toggle:1,
               stall:1, res_pat:0, res_w0:64'hFFFF_FFFF_FFFF_FFFF, exp_err:0};

    // Reset state (sampled while reset is still applied).
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_last", 64'(m_last), 64'(0));
    chk("rst_m_data", m_data, 64'(0));
    chk("rst_pa_en", 64'(pa_en), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chkw("rst_pa_m", WX'(pa_m), WX'(0));
    chkw("rst_pa_m_n", pa_m_n, WX'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_vec(tbl[i]);

    // Reuse requested straight after reset: flagged, loaded as full frame.
    do_reset();
    v = '{reuse:1, exp_beats:147, a_rand:1, a_lo:64'h0, stub_on:1, toggle:0,
          stall:0, res_pat:1, res_w0:64'h0, exp_err:1};
    run_vec(v);

    // phase_a never answers: timeout, then the key must be gone.
    do_reset();
    v = '{reuse:0, exp_beats:147, a_rand:1, a_lo:64'h0, stub_on:0, toggle:0,
          stall:0, res_pat:0, res_w0:64'h0, exp_err:1};
    run_vec(v);
    v = '{reuse:1, exp_beats:147, a_rand:1, a_lo:64'h0, stub_on:1, toggle:0,
          stall:0, res_pat:1, res_w0:64'h0, exp_err:1};
    run_vec(v);

    // Reset in the middle of loading discards the partial frame.
    for (int i = 0; i < 60; i++) send_beat({$urandom, $urandom}, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_s_ready", 64'(s_ready), 64'(0));
    chk("midrst_pa_en", 64'(pa_en), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_err", 64'(err), 64'(0));
    chkw("midrst_pa_m", WX'(pa_m), WX'(0));
    exp_m = '0; exp_mn = '0; exp_mp = '0; exp_a = '0; sb.delete();
    rst_n = 1'b1;
    @(negedge clk);
    v = '{reuse:0, exp_beats:147, a_rand:1, a_lo:64'h0, stub_on:1, toggle:0,
          stall:0, res_pat:0, res_w0:64'h1234, exp_err:0};
    run_vec(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
